// File: rtl/cpu_run_pkg.sv
// Shared types for the CPU run controller: FSM state encoding and CPU opcode values.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cpu_run_pkg;

   // Controller phases, in the order a normal run visits them
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      RESET = 3'd2,
      RUN   = 3'd3,
      DONE  = 3'd4
   } run_state_e;

   // Accumulator CPU opcodes
   localparam logic [2:0] HLT = 3'd0;
   localparam logic [2:0] SKZ = 3'd1;
   localparam logic [2:0] ADD = 3'd2;
   localparam logic [2:0] AND = 3'd3;
   localparam logic [2:0] XOR = 3'd4;
   localparam logic [2:0] LDA = 3'd5;
   localparam logic [2:0] STO = 3'd6;
   localparam logic [2:0] JMP = 3'd7;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Image-ROM read port plus CPU-memory write port seen by the run controller.
// Latency: ROM data returns one cycle after a read strobe.
// Backpressure: none; both ports accept one access per cycle.
interface cpu_run_ctrl_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
);
   import cpu_run_pkg::*;

   logic              rom_rd_en;
   logic [ADDR_W-1:0] rom_rd_addr;
   logic [DATA_W-1:0] rom_rd_data;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;

   // Controller side
   modport master (
      output rom_rd_en, rom_rd_addr, mem_we, mem_addr, mem_wdata,
      input  rom_rd_data
   );

   // ROM / memory side
   modport slave (
      input  rom_rd_en, rom_rd_addr, mem_we, mem_addr, mem_wdata,
      output rom_rd_data
   );

endinterface

// File: rtl/cpu_run_loader.sv
// Copies the whole image ROM into CPU memory, one word per cycle.
// Latency: 2**ADDR_W+1 cycles from start_i to the last write; load_done_o is high with that write.
// Backpressure: none; a synchronous reset aborts the copy and suppresses further writes.
module cpu_run_loader #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              start_i,
   output logic              load_done_o,
   cpu_run_ctrl_if.master    bus
);
   import cpu_run_pkg::*;

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
   localparam logic [DATA_W-1:0] ZERO_WORD = '0;

   logic              rd_en_q, rd_en_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              we_q;
   logic [ADDR_W-1:0] waddr_q;

   // Read sequencer: walk addresses 0..LAST, wrapping back to 0 after the last read
   always_comb begin
      rd_en_d   = rd_en_q;
      rd_addr_d = rd_addr_q;
      if (start_i) begin
         rd_en_d   = 1'b1;
         rd_addr_d = '0;
      end else if (rd_en_q) begin
         rd_addr_d = rd_addr_q + ADDR_W'(1);
         if (rd_addr_q == LAST_ADDR) begin
            rd_en_d = 1'b0;
         end
      end
   end

   // Read strobe/address registers and the one-cycle delayed write stage
   always_ff @(posedge clock) begin
      if (rst) begin
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         we_q      <= 1'b0;
         waddr_q   <= '0;
      end else begin
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
         we_q      <= rd_en_q;
         waddr_q   <= rd_addr_q;
      end
   end

   assign bus.rom_rd_en   = rd_en_q;
   assign bus.rom_rd_addr = rd_addr_q;
   assign bus.mem_we      = we_q;
   assign bus.mem_addr    = waddr_q;
   // ROM data arrives in the write cycle itself, so it is forwarded straight through
   assign bus.mem_wdata   = we_q ? bus.rom_rd_data : ZERO_WORD;
   assign load_done_o     = we_q && (waddr_q == LAST_ADDR);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: load image, hold CPU in reset, run, then report halt PC pass/fail or timeout.
// Latency: LOAD 2**ADDR_W+1 cycles, RESET RST_CYCLES cycles, RUN until halt edge or timeout.
// Backpressure: start is ignored while busy; optional CPU_TRACE_EN adds an opcode-change counter.
module cpu_run_ctrl
   import cpu_run_pkg::*;
#(
   parameter int          ADDR_W     = 5,
   parameter int          DATA_W     = 8,
   parameter int          TMO_W      = 16,
   parameter int unsigned RST_CYCLES = 2
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] expected_pc,
   input  logic [TMO_W-1:0]  timeout_limit,
   cpu_run_ctrl_if.master    mem_bus,
   output logic              cpu_rst_,
   input  logic              cpu_halt,
   input  logic [ADDR_W-1:0] cpu_pc,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              timeout,
   output logic [ADDR_W-1:0] halt_pc,
   output logic [TMO_W-1:0]  cycle_count
`ifdef CPU_TRACE_EN
   ,
   input  logic [2:0]        cpu_opcode,
   output logic [TMO_W-1:0]  instr_count
`endif
);

   localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RC_W-1:0] RST_LAST = RC_W'(RST_CYCLES - 1);

   run_state_e        state_q, state_d;
   logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
   logic [ADDR_W-1:0] exp_pc_q, exp_pc_d;
   logic [TMO_W-1:0]  tmo_lim_q, tmo_lim_d;
   logic              pass_q, pass_d;
   logic              timeout_q, timeout_d;
   logic [ADDR_W-1:0] halt_pc_q, halt_pc_d;
   logic [TMO_W-1:0]  cycle_cnt_q, cycle_cnt_d;
   logic              halt_prev_q;
   logic              halt_rise;
   logic              start_load;
   logic              load_done;

   cpu_run_loader #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_loader (
      .clock       (clock),
      .rst         (rst),
      .start_i     (start_load),
      .load_done_o (load_done),
      .bus         (mem_bus)
   );

   // Previous halt level is forced high outside RUN so a halt already
   // asserted on the first RUN cycle never looks like a rising edge.
   assign halt_rise = cpu_halt && !halt_prev_q;

   // Next-state and result update; halt takes priority over timeout
   always_comb begin
      state_d     = state_q;
      rst_cnt_d   = rst_cnt_q;
      exp_pc_d    = exp_pc_q;
      tmo_lim_d   = tmo_lim_q;
      pass_d      = pass_q;
      timeout_d   = timeout_q;
      halt_pc_d   = halt_pc_q;
      cycle_cnt_d = cycle_cnt_q;
      start_load  = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d     = LOAD;
               start_load  = 1'b1;
               exp_pc_d    = expected_pc;
               tmo_lim_d   = timeout_limit;
               pass_d      = 1'b0;
               timeout_d   = 1'b0;
               halt_pc_d   = '0;
               cycle_cnt_d = '0;
            end
         end
         LOAD: begin
            if (load_done) begin
               state_d   = RESET;
               rst_cnt_d = '0;
            end
         end
         RESET: begin
            if (rst_cnt_q == RST_LAST) begin
               state_d = RUN;
            end else begin
               rst_cnt_d = rst_cnt_q + RC_W'(1);
            end
         end
         RUN: begin
            if (cycle_cnt_q != '1) begin
               cycle_cnt_d = cycle_cnt_q + TMO_W'(1);
            end
            if (halt_rise) begin
               state_d   = DONE;
               halt_pc_d = cpu_pc;
               pass_d    = (cpu_pc == exp_pc_q);
               timeout_d = 1'b0;
            end else if ((tmo_lim_q != '0) && (cycle_cnt_q == tmo_lim_q - TMO_W'(1))) begin
               state_d   = DONE;
               timeout_d = 1'b1;
               pass_d    = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, sampled run settings and result registers
   always_ff @(posedge clock) begin
      if (rst) begin
         state_q     <= IDLE;
         rst_cnt_q   <= '0;
         exp_pc_q    <= '0;
         tmo_lim_q   <= '0;
         pass_q      <= 1'b0;
         timeout_q   <= 1'b0;
         halt_pc_q   <= '0;
         cycle_cnt_q <= '0;
         halt_prev_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         rst_cnt_q   <= rst_cnt_d;
         exp_pc_q    <= exp_pc_d;
         tmo_lim_q   <= tmo_lim_d;
         pass_q      <= pass_d;
         timeout_q   <= timeout_d;
         halt_pc_q   <= halt_pc_d;
         cycle_cnt_q <= cycle_cnt_d;
         halt_prev_q <= (state_q == RUN) ? cpu_halt : 1'b1;
      end
   end

   // CPU is released only while running and kept released in DONE for inspection
   assign cpu_rst_    = (state_q == RUN) || (state_q == DONE);
   assign busy        = (state_q == LOAD) || (state_q == RESET) || (state_q == RUN);
   assign done        = (state_q == DONE);
   assign pass        = pass_q;
   assign timeout     = timeout_q;
   assign halt_pc     = halt_pc_q;
   assign cycle_count = cycle_cnt_q;

`ifdef CPU_TRACE_EN
   logic [2:0]       opcode_prev_q;
   logic [TMO_W-1:0] instr_cnt_q;

   // Count opcode changes during RUN as a proxy for executed instructions
   always_ff @(posedge clock) begin
      if (rst) begin
         opcode_prev_q <= HLT;
         instr_cnt_q   <= '0;
      end else begin
         opcode_prev_q <= cpu_opcode;
         if (start_load) begin
            instr_cnt_q <= '0;
         end else if ((state_q == RUN) && (cpu_opcode != opcode_prev_q) && (instr_cnt_q != '1)) begin
            instr_cnt_q <= instr_cnt_q + TMO_W'(1);
         end
      end
   end

   assign instr_count = instr_cnt_q;
`endif

endmodule
